// File: rtl/multicycle_riscv_core.sv
// Multicycle RV32I-subset core: one shared ALU and one unified req/ready memory port.
// Illegal instructions, out-of-range registers and misaligned accesses trap to a sticky halt.
module multicycle_riscv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        retire,
  output logic        halted,
  output logic [31:0] pc_dbg
);

  // state    | meaning
  // FETCH    | read instruction at PC     DECODE  | read rs1/rs2, precompute branch target
  // EXEC_R/I | ALU op into ALUOut         ALUWB   | write ALUOut to rd
  // MEMADR   | compute/check address      MEMREAD | load word into MDR
  // MEMWB    | write MDR to rd            MEMWRITE| store B
  // BRANCH   | beq/bne resolve            JAL     | link and jump
  // HALT     | trapped until reset
  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] EXEC_R   = 4'd2;
  localparam logic [3:0] EXEC_I   = 4'd3;
  localparam logic [3:0] MEMADR   = 4'd4;
  localparam logic [3:0] MEMREAD  = 4'd5;
  localparam logic [3:0] MEMWRITE = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] MEMWB    = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JAL      = 4'd10;
  localparam logic [3:0] HALT     = 4'd11;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;

  localparam int IDXW = (NUM_REGS == 16) ? 4 : 5;

  logic [3:0]  state, next_state;
  logic [31:0] pc, old_pc, ir, a_q, b_q, alu_out, mdr;
  logic [31:0] rf [NUM_REGS];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_s, imm_b, imm_j;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];
  assign imm_i  = {{20{ir[31]}}, ir[31:20]};
  assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  logic transfer;
  assign transfer = mem_req & mem_ready;

  logic [3:0] dec_next;
  logic       uses_rd, uses_rs1, uses_rs2, f3_alu_ok;

  assign f3_alu_ok = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);

  always_comb begin
    dec_next = HALT;
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: if ((f7 == 7'b0000000 && f3_alu_ok) || (f7 == 7'b0100000 && f3 == 3'b000)) begin
        dec_next = EXEC_R; uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_I: if (f3_alu_ok) begin
        dec_next = EXEC_I; uses_rd = 1'b1; uses_rs1 = 1'b1;
      end
      OP_LOAD: if (f3 == 3'b010) begin
        dec_next = MEMADR; uses_rd = 1'b1; uses_rs1 = 1'b1;
      end
      OP_STORE: if (f3 == 3'b010) begin
        dec_next = MEMADR; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_BR: if (f3 == 3'b000 || f3 == 3'b001) begin
        dec_next = BRANCH; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        dec_next = JAL; uses_rd = 1'b1;
      end
      default: dec_next = HALT;
    endcase
    // In the 16-register file any index with bit 4 set names a missing register.
    if (NUM_REGS == 16 && ((uses_rd && rd[4]) || (uses_rs1 && rs1[4]) || (uses_rs2 && rs2[4])))
      dec_next = HALT;
  end

  logic [31:0] alu_a, alu_b, alu_y;
  logic [2:0]  alu_op, alu_f3_op;

  always_comb begin
    case (f3)
      3'b111:  alu_f3_op = ALU_AND;
      3'b110:  alu_f3_op = ALU_OR;
      3'b010:  alu_f3_op = ALU_SLT;
      default: alu_f3_op = (state == EXEC_R && f7[5]) ? ALU_SUB : ALU_ADD;
    endcase
  end

  always_comb begin
    alu_a  = pc;
    alu_b  = 32'd4;
    alu_op = ALU_ADD;
    case (state)
      DECODE: begin alu_a = old_pc; alu_b = imm_b; end
      EXEC_R: begin alu_a = a_q; alu_b = b_q; alu_op = alu_f3_op; end
      EXEC_I: begin alu_a = a_q; alu_b = imm_i; alu_op = alu_f3_op; end
      MEMADR: begin alu_a = a_q; alu_b = (opcode == OP_STORE) ? imm_s : imm_i; end
      JAL:    begin alu_a = old_pc; alu_b = imm_j; end
      default: ;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
      default: alu_y = alu_a + alu_b;
    endcase
  end

  logic br_taken;
  assign br_taken = (f3 == 3'b000) ? (a_q == b_q) : (a_q != b_q);

  always_comb begin
    next_state = state;
    case (state)
      FETCH:    if (transfer) next_state = DECODE;
      DECODE:   next_state = dec_next;
      EXEC_R,
      EXEC_I:   next_state = ALUWB;
      ALUWB,
      MEMWB:    next_state = FETCH;
      MEMADR:   if (alu_y[1:0] != 2'b00)   next_state = HALT;
                else if (opcode == OP_STORE) next_state = MEMWRITE;
                else                         next_state = MEMREAD;
      MEMREAD:  if (transfer) next_state = MEMWB;
      MEMWRITE: if (transfer) next_state = FETCH;
      BRANCH:   next_state = (br_taken && alu_out[1:0] != 2'b00) ? HALT : FETCH;
      JAL:      next_state = (alu_y[1:0] != 2'b00) ? HALT : FETCH;
      default:  next_state = HALT;
    endcase
  end

  logic        rf_we;
  logic [31:0] rf_wd;

  always_comb begin
    rf_we = 1'b0;
    rf_wd = alu_out;
    case (state)
      ALUWB: rf_we = 1'b1;
      MEMWB: begin rf_we = 1'b1; rf_wd = mdr; end
      JAL:   begin rf_we = (alu_y[1:0] == 2'b00); rf_wd = pc; end
      default: ;
    endcase
  end

  // A trapping branch/jal does not retire.
  assign retire    = (state == ALUWB) || (state == MEMWB) || (state == MEMWRITE && transfer) ||
                     ((state == BRANCH || state == JAL) && next_state == FETCH);
  assign halted    = (state == HALT);
  assign mem_we    = (state == MEMWRITE);
  assign mem_addr  = (state == FETCH) ? pc : alu_out;
  assign mem_wdata = b_q;
  assign pc_dbg    = pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      mem_req <= 1'b0;
      pc      <= RESET_PC;
      old_pc  <= '0;
      ir      <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_out <= '0;
      mdr     <= '0;
    end else begin
      state   <= next_state;
      mem_req <= (next_state == FETCH) || (next_state == MEMREAD) || (next_state == MEMWRITE);
      case (state)
        FETCH: if (transfer) begin
          ir     <= mem_rdata;
          old_pc <= pc;
          pc     <= alu_y;
        end
        DECODE: begin
          a_q     <= rf[rs1[IDXW-1:0]];
          b_q     <= rf[rs2[IDXW-1:0]];
          alu_out <= alu_y;
        end
        EXEC_R, EXEC_I, MEMADR: alu_out <= alu_y;
        MEMREAD: if (transfer) mdr <= mem_rdata;
        BRANCH:  if (br_taken && alu_out[1:0] == 2'b00) pc <= alu_out;
        JAL:     if (alu_y[1:0] == 2'b00) pc <= alu_y;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (rf_we && rd != 5'd0) begin
      rf[rd[IDXW-1:0]] <= rf_wd;
    end
  end

endmodule
